alu_multicycle: RTL

Parametrised, handshaked successor to the lab's 16-bit combinational ALU. It widens the operation set to eight ops, including an iterative shift-add multiply. It registers the result together with NZCV flags and exchanges operands and results over valid/ready interfaces. It sits between the operand register file and the writeback stage of the datapath.

---
 rtl/alu_multicycle_if.sv | 30 +++
 rtl/alu_multicycle.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_multicycle_if: operand/result valid-ready bundle for alu_multicycle
// Revision: 1.0
// ----------------------------------------------------------------------------
interface alu_multicycle_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       ALUControl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic [3:0]       flags;
  logic             busy;

  modport master (
    output in_valid, A, B, ALUControl, out_ready,
    input  in_ready, out_valid, ALUResult, flags, busy
  );

  modport slave (
    input  in_valid, A, B, ALUControl, out_ready,
    output in_ready, out_valid, ALUResult, flags, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_multicycle.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_multicycle: handshaked 8-op ALU with iterative shift-add MUL, NZCV flags
// Revision: 1.0
// ----------------------------------------------------------------------------
module alu_multicycle #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_multicycle_if.slave bus
);
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [3:0]           flags_q, flags_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [SHW-1:0]       cnt_q, cnt_d;

  logic [SHW-1:0]       shamt;
  logic [WIDTH:0]       add_full;
  logic [WIDTH:0]       sub_full;
  logic [WIDTH:0]       sll_full;
  logic [WIDTH:0]       srl_full;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c;
  logic                 alu_v;
  logic [2*WIDTH-1:0]   acc_step;

  assign shamt    = bus.B[SHW-1:0];
  assign add_full = {1'b0, bus.A} + {1'b0, bus.B};
  assign sub_full = {1'b0, bus.A} - {1'b0, bus.B};
  // The extra bit on each shift catches the last bit shifted out (zero for s=0).
  assign sll_full = {1'b0, bus.A} << shamt;
  assign srl_full = {bus.A, 1'b0} >> shamt;

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.ALUControl)
      OP_AND: alu_res = bus.A & bus.B;
      OP_OR:  alu_res = bus.A | bus.B;
      OP_XOR: alu_res = bus.A ^ bus.B;
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = ~sub_full[WIDTH];
        alu_v   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SLL: begin
        alu_res = sll_full[WIDTH-1:0];
        alu_c   = sll_full[WIDTH];
      end
      OP_SRL: begin
        alu_res = srl_full[WIDTH:1];
        alu_c   = srl_full[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (bus.ALUControl == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, bus.A};
            mplier_d = bus.B;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = ST_MUL;
          end else begin
            result_d = alu_res;
            flags_d  = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
            state_d  = ST_HOLD;
          end
        end
      end
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        // Final iteration writes its sum straight into the result registers.
        if (cnt_q == CNT_LAST) begin
          result_d = acc_step[WIDTH-1:0];
          flags_d  = {acc_step[WIDTH-1], acc_step[WIDTH-1:0] == '0,
                      |acc_step[2*WIDTH-1:WIDTH], 1'b0};
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.busy      = (state_q == ST_MUL);
  assign bus.ALUResult = result_q;
  assign bus.flags     = flags_q;

endmodule
`default_nettype wire
